nn_output_layer: RTL and testbench
==================================

Name: nn_output_layer

Overview:
- Second (output) layer of the MNIST inference pipeline; sits directly downstream of the hidden-layer engine.
- After the hidden layer signals done, it reads the NUM_HID hidden-node sums from SDRAM and applies ReLU to each one.
- It forms NUM_OUT class scores by multiply-accumulating those values against output-layer weights.
- It writes each score back to memory, writes the argmax digit, and holds done.

Parameters:
- NUM_HID, 200, hidden nodes per class
- NUM_OUT, 10, output classes
- BASE_ADDR_NODE, 32'h132A2, hidden-node array base (upstream output)
- BASE_ADDR_WEIGHT, 32'h1000000, class-major weights: (c,i) at base+2*(c*NUM_HID+i)
- BASE_ADDR_SCORE, 32'h13500, score array base, 16-bit per class
- BASE_ADDR_RESULT, 32'h13520, predicted-digit word
- SCORE_SHIFT, 8, arithmetic right shift applied before the 16-bit score writeback

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ready  in  1  start request, level; tied to the upstream done
- waitrequest  in  1  Avalon-MM slave stall
- readdatavalid  in  1  read data valid
- readdata  in  16  read data
- read_n  out  1  active-low read strobe
- write_n  out  1  active-low write strobe
- chipselect  out  1  constant 1
- byteenable  out  2  constant 2'b11
- address  out  32  byte address
- writedata  out  16  write data
- done  out  1  high in DONE_ST
- result  out  4  predicted digit; valid while done=1
- toHexLed  out  32  {20'b0, state[3:0], 4'b0, result}

Behaviour:
- Reset (async, any time): state=IDLE_ST, read_n=1, write_n=1, done=0, result=0. Counters, accumulator and best registers clear. Any in-flight Avalon transaction is abandoned.
- States and transitions:
  - IDLE_ST -> READ_NODE_ST when ready=1.
  - READ_NODE_ST: read_n=0, address=node_addr. Advance to WAIT_NODE_ST on !waitrequest.
  - WAIT_NODE_ST: on readdatavalid, latch h = (readdata<0) ? 0 : readdata (ReLU); -> READ_W_ST.
  - READ_W_ST / WAIT_W_ST: same pattern on weight_addr; latch w; -> MAC_ST.
  - MAC_ST (1 cycle): acc += h*w, using a 32-bit signed product and 40-bit signed accumulator. node_addr+=2, weight_addr+=2, i+=1. -> READ_NODE_ST if i<NUM_HID, else WRITE_SCORE_ST.
  - WRITE_SCORE_ST: write_n=0, address=score_addr, writedata=sat16(acc>>>SCORE_SHIFT). On !waitrequest -> NEXT_CLASS_ST.
  - NEXT_CLASS_ST (1 cycle): if c==0 or acc>best_acc (strict, full 40-bit compare), then best_acc=acc and best_idx=c. Then acc=0, i=0, node_addr=BASE_ADDR_NODE, score_addr+=2, c+=1. weight_addr is not reset; it continues sequentially. -> READ_NODE_ST if c+1<NUM_OUT, else WRITE_RESULT_ST.
  - WRITE_RESULT_ST: write_n=0, address=BASE_ADDR_RESULT, writedata={12'b0,best_idx}. On !waitrequest, result<=best_idx, -> DONE_ST.
  - DONE_ST: done=1. -> IDLE_ST when ready=0; IDLE_ST re-initialises all addresses and counters.
- Strobe and address rules:
  - read_n and write_n are never low together.
  - Strobes and address stay stable while waitrequest=1.
  - readdatavalid is ignored outside the WAIT_* states.
  - Slave read latency is >=1 cycle after accept.
- sat16: values >32767 clamp to 16'h7FFF; values <-32768 clamp to 16'h8000.
- Ties resolve to the lowest class index.
- ready falling mid-computation is ignored; the run completes, then DONE_ST exits immediately.
- Total transactions per run: 2*NUM_HID*NUM_OUT reads and NUM_OUT+1 writes.

Decomposition:
- Package nn_pkg holds:
  - state encoding localparams (4-bit);
  - address-map constants shared with the hidden layer;
  - ACC_W=40;
  - a sat16 function.
- One sub-module is natural: nn_argmax_tracker (clear, update strobe, acc_in, class_idx -> best_idx, best_acc).

Test Plan:
- Memory model, NUM_HID=4, NUM_OUT=3, SCORE_SHIFT=0. Nodes {1,2,3,4}; weights class0 all 1, class1 all 2, class2 all 0 -> scores 10,20,0 written at SCORE+0/2/4; result=1 at RESULT; done=1.
- ReLU: nodes {-5,3,0,0}, class0 weights {100,1,1,1} -> score0=3.
- Tie: all three classes use identical weights -> result=0.
- Saturation: nodes all 32767, weights all 32767 -> 16'h7FFF. Weights all -32768 -> 16'h8000.
- Backpressure: waitrequest high 5 cycles per access, readdatavalid 3 cycles late -> same results as the first scenario; read_n low exactly until accept; address stable throughout.
- Reset pulse during WAIT_W_ST of class 1 -> read_n=1, done=0, state=IDLE_ST within the same cycle. A rerun with ready=1 produces the correct scores and result.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the MNIST inference layers: FSM states, address map,
// accumulator width and score saturation.
package nn_pkg;

    typedef enum logic [3:0] {
        IDLE_ST         = 4'd0,
        READ_NODE_ST    = 4'd1,
        WAIT_NODE_ST    = 4'd2,
        READ_W_ST       = 4'd3,
        WAIT_W_ST       = 4'd4,
        MAC_ST          = 4'd5,
        WRITE_SCORE_ST  = 4'd6,
        NEXT_CLASS_ST   = 4'd7,
        WRITE_RESULT_ST = 4'd8,
        DONE_ST         = 4'd9
    } state_t;

    localparam logic [31:0] ADDR_NODE   = 32'h132A2;
    localparam logic [31:0] ADDR_WEIGHT = 32'h1000000;
    localparam logic [31:0] ADDR_SCORE  = 32'h13500;
    localparam logic [31:0] ADDR_RESULT = 32'h13520;

    localparam int unsigned ACC_W = 40;

    function automatic logic [15:0] sat16(input logic signed [ACC_W-1:0] v);
        if (v > 40'sd32767)
            return 16'h7FFF;
        else if (v < -40'sd32768)
            return 16'h8000;
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/nn_output_layer_if.sv
// Avalon-MM master bus used by the output layer to reach SDRAM.
interface nn_output_layer_if;
    logic        read_n;
    logic        write_n;
    logic        chipselect;
    logic [1:0]  byteenable;
    logic [31:0] address;
    logic [15:0] writedata;
    logic        waitrequest;
    logic        readdatavalid;
    logic [15:0] readdata;

    modport master (
        output read_n, write_n, chipselect, byteenable, address, writedata,
        input  waitrequest, readdatavalid, readdata
    );

    modport slave (
        input  read_n, write_n, chipselect, byteenable, address, writedata,
        output waitrequest, readdatavalid, readdata
    );
endinterface

// File: rtl/nn_argmax_tracker.sv
// Running argmax over class scores; first class always loads, later classes
// replace it only when strictly greater, so ties keep the lowest index.
module nn_argmax_tracker
    import nn_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    update,
    input  logic signed [ACC_W-1:0] acc_in,
    input  logic [3:0]              class_idx,
    output logic [3:0]              best_idx
);

    logic signed [ACC_W-1:0] best_acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            best_acc <= '0;
            best_idx <= '0;
        end else if (clear) begin
            best_acc <= '0;
            best_idx <= '0;
        end else if (update && (class_idx == 4'd0 || acc_in > best_acc)) begin
            best_acc <= acc_in;
            best_idx <= class_idx;
        end
    end

endmodule

// File: rtl/nn_output_layer.sv
// Output layer: ReLU on hidden sums, MAC against class weights, score and
// argmax writeback over an Avalon-MM master.
module nn_output_layer
    import nn_pkg::*;
#(
    parameter int unsigned NUM_HID          = 200,
    parameter int unsigned NUM_OUT          = 10,
    parameter logic [31:0] BASE_ADDR_NODE   = ADDR_NODE,
    parameter logic [31:0] BASE_ADDR_WEIGHT = ADDR_WEIGHT,
    parameter logic [31:0] BASE_ADDR_SCORE  = ADDR_SCORE,
    parameter logic [31:0] BASE_ADDR_RESULT = ADDR_RESULT,
    parameter int unsigned SCORE_SHIFT      = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ready,
    nn_output_layer_if.master   avm,
    output logic                done,
    output logic [3:0]          result,
    output logic [31:0]         toHexLed
);

    state_t                  state, state_nxt;
    logic signed [15:0]      h, w;
    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] acc;
    logic [15:0]             idx;
    logic [3:0]              cls;
    logic [31:0]             node_addr, weight_addr, score_addr;
    logic [3:0]              best_idx;

    assign prod           = 32'(h) * 32'(w);
    assign avm.chipselect = 1'b1;
    assign avm.byteenable = 2'b11;
    assign toHexLed       = {20'b0, 4'(state), 4'b0, result};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE_ST;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        avm.read_n    = 1'b1;
        avm.write_n   = 1'b1;
        avm.address   = '0;
        avm.writedata = '0;
        done          = 1'b0;
        unique case (state)
            IDLE_ST:      if (ready) state_nxt = READ_NODE_ST;
            READ_NODE_ST: begin
                avm.read_n  = 1'b0;
                avm.address = node_addr;
                if (!avm.waitrequest) state_nxt = WAIT_NODE_ST;
            end
            WAIT_NODE_ST: if (avm.readdatavalid) state_nxt = READ_W_ST;
            READ_W_ST: begin
                avm.read_n  = 1'b0;
                avm.address = weight_addr;
                if (!avm.waitrequest) state_nxt = WAIT_W_ST;
            end
            WAIT_W_ST:    if (avm.readdatavalid) state_nxt = MAC_ST;
            MAC_ST:
                state_nxt = ((idx + 16'd1) < 16'(NUM_HID)) ? READ_NODE_ST : WRITE_SCORE_ST;
            WRITE_SCORE_ST: begin
                avm.write_n   = 1'b0;
                avm.address   = score_addr;
                avm.writedata = sat16(acc >>> SCORE_SHIFT);
                if (!avm.waitrequest) state_nxt = NEXT_CLASS_ST;
            end
            NEXT_CLASS_ST:
                state_nxt = ((cls + 4'd1) < 4'(NUM_OUT)) ? READ_NODE_ST : WRITE_RESULT_ST;
            WRITE_RESULT_ST: begin
                avm.write_n   = 1'b0;
                avm.address   = BASE_ADDR_RESULT;
                avm.writedata = {12'b0, best_idx};
                if (!avm.waitrequest) state_nxt = DONE_ST;
            end
            DONE_ST: begin
                done = 1'b1;
                if (!ready) state_nxt = IDLE_ST;
            end
            default:      state_nxt = IDLE_ST;
        endcase
    end

    // Weight address keeps running across classes: the array is class-major.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h           <= '0;
            w           <= '0;
            acc         <= '0;
            idx         <= '0;
            cls         <= '0;
            node_addr   <= BASE_ADDR_NODE;
            weight_addr <= BASE_ADDR_WEIGHT;
            score_addr  <= BASE_ADDR_SCORE;
            result      <= '0;
        end else begin
            unique case (state)
                IDLE_ST: begin
                    acc         <= '0;
                    idx         <= '0;
                    cls         <= '0;
                    node_addr   <= BASE_ADDR_NODE;
                    weight_addr <= BASE_ADDR_WEIGHT;
                    score_addr  <= BASE_ADDR_SCORE;
                end
                WAIT_NODE_ST:
                    if (avm.readdatavalid) h <= avm.readdata[15] ? '0 : avm.readdata;
                WAIT_W_ST:
                    if (avm.readdatavalid) w <= avm.readdata;
                MAC_ST: begin
                    acc         <= acc + ACC_W'(prod);
                    node_addr   <= node_addr + 32'd2;
                    weight_addr <= weight_addr + 32'd2;
                    idx         <= idx + 16'd1;
                end
                NEXT_CLASS_ST: begin
                    acc        <= '0;
                    idx        <= '0;
                    node_addr  <= BASE_ADDR_NODE;
                    score_addr <= score_addr + 32'd2;
                    cls        <= cls + 4'd1;
                end
                WRITE_RESULT_ST:
                    if (!avm.waitrequest) result <= best_idx;
                default: ;
            endcase
        end
    end

    nn_argmax_tracker u_argmax (
        .clk       (clk),
        .reset     (reset),
        .clear     (state == IDLE_ST),
        .update    (state == NEXT_CLASS_ST),
        .acc_in    (acc),
        .class_idx (cls),
        .best_idx  (best_idx)
    );

endmodule

// File: tb/tb_nn_output_layer.sv
// Bench for nn_output_layer: Avalon memory slave with random stalls/latency,
// reference scores computed directly from the layer arithmetic.
module tb_nn_output_layer;
    import nn_pkg::*;

    localparam int H = 4;
    localparam int O = 3;
    localparam int unsigned NODE_B  = 32'h132A2;
    localparam int unsigned W_B     = 32'h1000000;
    localparam int unsigned SCORE_B = 32'h13500;
    localparam int unsigned RES_B   = 32'h13520;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic        done;
    logic [3:0]  result;
    logic [31:0] toHexLed;

    nn_output_layer_if avm_bus();

    nn_output_layer #(
        .NUM_HID     (H),
        .NUM_OUT     (O),
        .SCORE_SHIFT (0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ready    (ready),
        .avm      (avm_bus),
        .done     (done),
        .result   (result),
        .toHexLed (toHexLed)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mem [int unsigned];
    int node [H];
    int wt   [O][H];

    int stall_cfg   = 0;
    int lat_cfg     = 1;
    bit rand_timing = 1'b0;
    bit stray_en    = 1'b0;
    int n_reads     = 0;
    int n_writes    = 0;

    bit          rd_pending = 1'b0;
    int          rd_cnt     = 0;
    logic [15:0] rd_data    = '0;
    int          stall_left = -1;
    bit          prev_req   = 1'b0;
    bit          prev_wait  = 1'b0;
    bit          prev_acc   = 1'b0;
    logic [49:0] prev_bus   = '0;
    logic [49:0] bus;
    bit          req;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory slave: decisions at negedge, so the DUT samples them at the next posedge.
    initial begin
        avm_bus.waitrequest   = 1'b0;
        avm_bus.readdatavalid = 1'b0;
        avm_bus.readdata      = '0;
        forever begin
            @(negedge clk);
            bus = {avm_bus.read_n, avm_bus.write_n, avm_bus.address, avm_bus.writedata};
            req = !avm_bus.read_n || !avm_bus.write_n;
            avm_bus.readdatavalid = 1'b0;
            if (reset) begin
                rd_pending = 1'b0;
                stall_left = -1;
                prev_req   = 1'b0;
                prev_acc   = 1'b0;
                avm_bus.waitrequest = 1'b0;
                continue;
            end
            if (req) check("strobe_excl", 64'(avm_bus.read_n | avm_bus.write_n), 64'd1);
            if (prev_req && prev_wait) check("hold_while_wait", 64'(bus), 64'(prev_bus));
            if (prev_acc) check("release_after_accept", 64'({avm_bus.read_n, avm_bus.write_n}), 64'd3);
            if (rd_pending) begin
                if (rd_cnt <= 1) begin
                    avm_bus.readdatavalid = 1'b1;
                    avm_bus.readdata      = rd_data;
                    rd_pending            = 1'b0;
                end else begin
                    rd_cnt--;
                end
            end else if (stray_en && avm_bus.read_n && $urandom_range(0, 3) == 0) begin
                avm_bus.readdatavalid = 1'b1;
                avm_bus.readdata      = 16'($urandom);
            end
            prev_acc = 1'b0;
            if (req) begin
                if (stall_left < 0)
                    stall_left = rand_timing ? int'($urandom_range(0, stall_cfg)) : stall_cfg;
                if (stall_left > 0) begin
                    avm_bus.waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    avm_bus.waitrequest = 1'b0;
                    stall_left = -1;
                    prev_acc   = 1'b1;
                    if (!avm_bus.read_n) begin
                        rd_pending = 1'b1;
                        rd_data    = mem.exists(int'(avm_bus.address)) ? mem[int'(avm_bus.address)] : 16'hBAD0;
                        rd_cnt     = rand_timing ? int'($urandom_range(1, lat_cfg)) : lat_cfg;
                        n_reads++;
                    end else begin
                        mem[int'(avm_bus.address)] = avm_bus.writedata;
                        n_writes++;
                    end
                end
            end else begin
                avm_bus.waitrequest = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            prev_req  = req;
            prev_wait = avm_bus.waitrequest;
            prev_bus  = bus;
        end
    end

    task automatic load_mem();
        mem.delete();
        for (int i = 0; i < H; i++) mem[NODE_B + 2 * i] = 16'(node[i]);
        for (int c = 0; c < O; c++)
            for (int i = 0; i < H; i++) mem[W_B + 2 * (c * H + i)] = 16'(wt[c][i]);
        for (int c = 0; c < O; c++) mem[SCORE_B + 2 * c] = 16'hDEAD;
        mem[RES_B] = 16'hDEAD;
    endtask

    task automatic run_case(input string name, input bit drop_ready);
        longint      acc, best_acc;
        int          best;
        logic [15:0] exp_sc [O];
        bit          hit;
        load_mem();
        best = 0;
        best_acc = 0;
        for (int c = 0; c < O; c++) begin
            acc = 0;
            for (int i = 0; i < H; i++)
                acc += longint'((node[i] < 0) ? 0 : node[i]) * longint'(wt[c][i]);
            if (acc > 32767)       exp_sc[c] = 16'h7FFF;
            else if (acc < -32768) exp_sc[c] = 16'h8000;
            else                   exp_sc[c] = 16'(acc);
            if (c == 0 || acc > best_acc) begin
                best_acc = acc;
                best     = c;
            end
        end
        n_reads  = 0;
        n_writes = 0;
        ready    = 1'b1;
        hit      = 1'b0;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (drop_ready && k == 30) ready = 1'b0;
            if (done) begin
                hit = 1'b1;
                break;
            end
        end
        check({name, ":completed"}, 64'(hit), 64'd1);
        if (hit) begin
            check({name, ":result"}, 64'(result), 64'(best));
            check({name, ":hexled"}, 64'(toHexLed), 64'({20'b0, 4'd9, 4'b0, 4'(best)}));
            for (int c = 0; c < O; c++)
                check($sformatf("%s:score%0d", name, c), 64'(mem[SCORE_B + 2 * c]), 64'(exp_sc[c]));
            check({name, ":result_word"}, 64'(mem[RES_B]), 64'(best));
            check({name, ":reads"}, 64'(n_reads), 64'(2 * H * O));
            check({name, ":writes"}, 64'(n_writes), 64'(O + 1));
            if (!drop_ready) begin
                @(negedge clk);
                check({name, ":done_held"}, 64'(done), 64'd1);
            end
        end
        ready = 1'b0;
        @(negedge clk);
        check({name, ":done_dropped"}, 64'(done), 64'd0);
        check({name, ":back_idle"}, 64'(toHexLed[11:8]), 64'(IDLE_ST));
    endtask

    task automatic set_basic();
        for (int i = 0; i < H; i++) begin
            node[i]  = i + 1;
            wt[0][i] = 1;
            wt[1][i] = 2;
            wt[2][i] = 0;
        end
    endtask

    task automatic set_random(input bit full);
        for (int i = 0; i < H; i++)
            node[i] = full ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 400)) - 200;
        for (int c = 0; c < O; c++)
            for (int i = 0; i < H; i++)
                wt[c][i] = full ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 400)) - 200;
    endtask

    initial begin
        bit hit;
        reset = 1'b1;
        ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst:read_n", 64'(avm_bus.read_n), 64'd1);
        check("rst:write_n", 64'(avm_bus.write_n), 64'd1);
        check("rst:done", 64'(done), 64'd0);
        check("rst:result", 64'(result), 64'd0);
        check("rst:hexled", 64'(toHexLed), 64'd0);
        check("rst:const", 64'({avm_bus.chipselect, avm_bus.byteenable}), 64'd7);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_wait_ready", 64'(toHexLed[11:8]), 64'(IDLE_ST));

        set_basic();
        run_case("basic", 1'b0);

        set_random(1'b0);
        node[0] = -5; node[1] = 3; node[2] = 0; node[3] = 0;
        wt[0][0] = 100; wt[0][1] = 1; wt[0][2] = 1; wt[0][3] = 1;
        run_case("relu", 1'b0);

        set_random(1'b0);
        for (int c = 1; c < O; c++)
            for (int i = 0; i < H; i++) wt[c][i] = wt[0][i];
        run_case("tie", 1'b0);

        for (int i = 0; i < H; i++) begin
            node[i] = 32767;
            for (int c = 0; c < O; c++) wt[c][i] = 32767;
        end
        run_case("sat_pos", 1'b0);
        for (int c = 0; c < O; c++)
            for (int i = 0; i < H; i++) wt[c][i] = -32768;
        run_case("sat_neg", 1'b0);

        stall_cfg = 5;
        lat_cfg   = 4;
        set_basic();
        run_case("backpressure", 1'b0);

        rand_timing = 1'b1;
        stray_en    = 1'b1;
        for (int r = 0; r < 6; r++) begin
            stall_cfg = 4;
            lat_cfg   = 4;
            set_random(r[0]);
            run_case($sformatf("rand%0d", r), r == 3);
        end

        set_basic();
        load_mem();
        n_writes = 0;
        ready    = 1'b1;
        hit      = 1'b0;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (n_writes >= 1 && toHexLed[11:8] == 4'(WAIT_W_ST)) begin
                hit = 1'b1;
                break;
            end
        end
        check("mid_reset:reached_wait_w", 64'(hit), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_reset:read_n", 64'(avm_bus.read_n), 64'd1);
        check("mid_reset:done", 64'(done), 64'd0);
        check("mid_reset:state", 64'(toHexLed[11:8]), 64'(IDLE_ST));
        ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        set_random(1'b0);
        run_case("rerun", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
